// File: rtl/regfile_read_port_if.sv
// Bus bundle for the register file: one write port plus a paired read request
// (ports A and B) with registered read results.
//
// Read handshake: a read is accepted at a rising clk when rd_en=1 and stall=0.
// There is no ready signal because the file never back-pressures. One cycle
// after an accepted read, rd_valid=1 and rd_data_a/b carry the result. While
// stall=1, rd_valid and rd_data_a/b hold their values and rd_en is ignored.
// A non-stalled edge with rd_en=0 drops rd_valid.
interface regfile_read_port_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int SELECT_WIDTH = 5
);
  logic                    wr_en;
  logic [SELECT_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    rd_en;
  logic                    stall;
  logic [SELECT_WIDTH-1:0] rd_addr_a;
  logic [SELECT_WIDTH-1:0] rd_addr_b;
  logic [DATA_WIDTH-1:0]   rd_data_a;
  logic [DATA_WIDTH-1:0]   rd_data_b;
  logic                    rd_valid;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, stall, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, rd_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, stall, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, rd_valid
  );
endinterface

// File: rtl/regfile_read_port.sv
// Register file with one write port and two registered read ports.
// Word 0 reads as zero and ignores writes. A read of the word being written at
// the same edge returns the incoming data (bypass). Stall freezes the read
// outputs. Every output comes straight from a flop.
module regfile_read_port #(
  parameter int DATA_WIDTH   = 32,
  parameter int SELECT_WIDTH = 5
) (
  input logic                clk,
  input logic                rst,
  regfile_read_port_if.slave bus
);
  localparam int DEPTH = 2 ** SELECT_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]      wr_dec;
  logic                  rd_accept;
  logic [DATA_WIDTH-1:0] rd_data_a_q, rd_data_a_d;
  logic [DATA_WIDTH-1:0] rd_data_b_q, rd_data_b_d;
  logic                  rd_valid_q, rd_valid_d;

  // One-hot write enable per word. Word 0 never gets an enable, so it stays zero.
  always_comb begin
    wr_dec              = '0;
    wr_dec[bus.wr_addr] = bus.wr_en;
    wr_dec[0]           = 1'b0;
  end

  // Next storage contents: each enabled word takes the write data.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = wr_dec[i] ? bus.wr_data : mem_q[i];
    end
  end

  // Read selection. wr_dec is nonzero only for a live write to a nonzero
  // address, so it doubles as the bypass hit for each port.
  always_comb begin
    rd_accept   = bus.rd_en && !bus.stall;
    rd_data_a_d = rd_data_a_q;
    rd_data_b_d = rd_data_b_q;
    rd_valid_d  = bus.stall ? rd_valid_q : bus.rd_en;
    if (rd_accept) begin
      if (bus.rd_addr_a == '0)
        rd_data_a_d = '0;
      else if (wr_dec[bus.rd_addr_a])
        rd_data_a_d = bus.wr_data;
      else
        rd_data_a_d = mem_q[bus.rd_addr_a];

      if (bus.rd_addr_b == '0)
        rd_data_b_d = '0;
      else if (wr_dec[bus.rd_addr_b])
        rd_data_b_d = bus.wr_data;
      else
        rd_data_b_d = mem_q[bus.rd_addr_b];
    end
  end

  // State update. Reset clears storage and read outputs, and it overrides
  // write, read and stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  // Outputs are taken directly from the flops.
  assign bus.rd_data_a = rd_data_a_q;
  assign bus.rd_data_b = rd_data_b_q;
  assign bus.rd_valid  = rd_valid_q;
endmodule

// File: tb/tb_regfile_read_port.sv
// Directed bench for regfile_read_port. A behavioural reference model tracks
// the file contents and expected outputs. A per-cycle compare checks the DUT
// against that model. Directed vectors with literal expectations pin the model.
module tb_regfile_read_port;
  localparam int DW = 32;
  localparam int SW = 5;
  localparam int N  = 2 ** SW;

  logic clk;
  logic rst;
  regfile_read_port_if #(.DATA_WIDTH(DW), .SELECT_WIDTH(SW)) rf ();

  regfile_read_port #(.DATA_WIDTH(DW), .SELECT_WIDTH(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (rf.slave)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [DW-1:0] m_mem [N];
  logic [DW-1:0] m_a, m_b;
  logic          m_valid;
  logic          m_known = 1'b0;

  function automatic logic [DW-1:0] m_word(input logic [SW-1:0] x);
    if (x == 0) return '0;
    if (rf.wr_en && rf.wr_addr == x) return rf.wr_data;
    return m_mem[x];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) m_mem[i] <= '0;
      m_a     <= '0;
      m_b     <= '0;
      m_valid <= 1'b0;
      m_known <= 1'b1;
    end else begin
      if (!rf.stall) begin
        if (rf.rd_en) begin
          m_a     <= m_word(rf.rd_addr_a);
          m_b     <= m_word(rf.rd_addr_b);
          m_valid <= 1'b1;
        end else begin
          m_valid <= 1'b0;
        end
      end
      if (rf.wr_en && rf.wr_addr != 0) m_mem[rf.wr_addr] <= rf.wr_data;
    end
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, just after each edge.
  always @(posedge clk) begin
    #1;
    if (m_known) begin
      check("model_valid", {31'b0, rf.rd_valid}, {31'b0, m_valid});
      if (m_valid) begin
        check("model_a", rf.rd_data_a, m_a);
        check("model_b", rf.rd_data_b, m_b);
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a falling edge. It applies the inputs and returns at the next
  // falling edge, so the outputs then show the effect of the edge between.
  task automatic cyc(input logic r, input logic we, input logic [SW-1:0] wa,
                     input logic [DW-1:0] wd, input logic re, input logic st,
                     input logic [SW-1:0] aa, input logic [SW-1:0] ab);
    rst          = r;
    rf.wr_en     = we;
    rf.wr_addr   = wa;
    rf.wr_data   = wd;
    rf.rd_en     = re;
    rf.stall     = st;
    rf.rd_addr_a = aa;
    rf.rd_addr_b = ab;
    @(negedge clk);
  endtask

  task automatic expect_out(input string name, input logic [DW-1:0] ea,
                            input logic [DW-1:0] eb, input logic ev);
    check({name, "_a"}, rf.rd_data_a, ea);
    check({name, "_b"}, rf.rd_data_b, eb);
    check({name, "_valid"}, {31'b0, rf.rd_valid}, {31'b0, ev});
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1;
    rf.wr_en = 0; rf.wr_addr = 0; rf.wr_data = 0;
    rf.rd_en = 0; rf.stall = 0; rf.rd_addr_a = 0; rf.rd_addr_b = 0;
    @(negedge clk);

    // Reset, then basic write/read
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    expect_out("reset", 32'h0, 32'h0, 1'b0);
    cyc(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    check("idle_valid", {31'b0, rf.rd_valid}, 32'h0);
    cyc(0, 0, 0, 0, 1, 0, 5, 0);
    expect_out("basic", 32'hDEADBEEF, 32'h0, 1'b1);

    // Bypass with both ports on the word being written
    cyc(0, 1, 7, 32'h11111111, 0, 0, 0, 0);
    cyc(0, 1, 7, 32'h22222222, 1, 0, 7, 7);
    expect_out("bypass", 32'h22222222, 32'h22222222, 1'b1);

    // Register 0 ignores writes and reads as zero
    cyc(0, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 7);
    expect_out("reg0_same_edge", 32'h0, 32'h22222222, 1'b1);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    expect_out("reg0_again", 32'h0, 32'h0, 1'b1);

    // Stall hold, with writes and address changes underneath
    cyc(0, 1, 3, 32'h00000033, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 3, 0);
    expect_out("pre_stall", 32'h33, 32'h0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 3, 32'h44, 1, 1, 9, 0);
      expect_out($sformatf("stall%0d", k), 32'h33, 32'h0, 1'b1);
    end
    cyc(0, 0, 0, 0, 1, 0, 3, 0);
    expect_out("post_stall", 32'h44, 32'h0, 1'b1);
    cyc(0, 0, 0, 0, 0, 0, 3, 0);
    check("rd_en_low_valid", {31'b0, rf.rd_valid}, 32'h0);

    // Reset during a stall clears the held outputs
    cyc(0, 0, 0, 0, 1, 0, 3, 3);
    cyc(1, 0, 0, 0, 1, 1, 3, 3);
    expect_out("reset_in_stall", 32'h0, 32'h0, 1'b0);

    // Reset in the middle of operation
    for (int i = 1; i < N; i++) cyc(0, 1, i[SW-1:0], i, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 31, 1);
    expect_out("filled", 32'd31, 32'd1, 1'b1);
    cyc(1, 1, 4, 32'h99, 1, 0, 31, 1);
    expect_out("mid_reset", 32'h0, 32'h0, 1'b0);
    cyc(0, 0, 0, 0, 1, 0, 31, 1);
    expect_out("after_reset", 32'h0, 32'h0, 1'b1);

    // Back-to-back sweep: B bypasses the current write, A sees the previous one
    for (int i = 1; i < N; i++) begin
      logic [DW-1:0] v;
      logic [DW-1:0] vp;
      v  = i * 32'h01010101;
      vp = (i - 1) * 32'h01010101;
      cyc(0, 1, i[SW-1:0], v, 1, 0, SW'(i - 1), i[SW-1:0]);
      expect_out($sformatf("sweep%0d", i), vp, v, 1'b1);
    end

    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/regfile_read_port.md
# regfile_read_port

Register file for the pipelined datapath: 2^SELECT_WIDTH words written through one write port and read through two registered read ports (A and B). The write side decodes the write address to a one-hot enable, gated by the write strobe. The read side selects one word per port, with write-to-read bypass and a stall hold for the decode stage. Read results feed the ID/EX pipeline register directly.

## Interface
- DATA_WIDTH, 32, width of each register word
- SELECT_WIDTH, 5, address width; depth = 2^SELECT_WIDTH words
- clk  input  1  rising-edge clock, only clock in the block
- rst  input  1  synchronous, active-high reset
- wr_en  input  1  write strobe, sampled at rising clk
- wr_addr  input  SELECT_WIDTH  write address
- wr_data  input  DATA_WIDTH  write data
- rd_en  input  1  read request for both ports
- stall  input  1  hold read outputs (pipeline freeze)
- rd_addr_a  input  SELECT_WIDTH  port A read address
- rd_addr_b  input  SELECT_WIDTH  port B read address
- rd_data_a  output  DATA_WIDTH  registered port A data
- rd_data_b  output  DATA_WIDTH  registered port B data
- rd_valid  output  1  rd_data_a/b hold the result of an accepted read

## Operation
- Storage: 2^SELECT_WIDTH × DATA_WIDTH flops. Address 0 is hardwired zero. Writes to 0 are discarded and reads of 0 return 0.
- Write: at a rising clk with wr_en=1, rst=0 and wr_addr≠0, mem[wr_addr] ← wr_data. The write enable per word is a one-hot decode of wr_addr ANDed with wr_en. Writes proceed regardless of stall.
- Read accept: a read is accepted at a rising clk when rd_en=1, stall=0 and rst=0.
- Accepted read:
  - rd_data_a ← word(rd_addr_a); rd_data_b ← word(rd_addr_b); rd_valid ← 1.
- Rules for word(x):
  - x=0 → 0.
  - If wr_en=1 and wr_addr=x≠0 at the same edge → wr_data (bypass: new value, never stale).
  - Otherwise → mem[x].
- Port A and port B may use the same address. Both return the same value, including under bypass.
- stall=1: rd_data_a, rd_data_b and rd_valid hold their current values. rd_en is ignored. The held data is not refreshed even if the underlying word is written.
- stall=0, rd_en=0: rd_valid ← 0. rd_data_a/b hold their last value and are don't-care for consumers.
- Reset (rst=1 at an edge): every mem word ← 0, rd_data_a/b ← 0, rd_valid ← 0.
  - Reset overrides a simultaneous wr_en, rd_en or stall.
  - Reset mid-stall clears the held outputs.
- Address inputs are full width; there are no out-of-range addresses. No X may propagate from unwritten words, because reset zeroes them.

## Timing
- Write latency: data written at edge N is visible in mem after edge N.
  - Via bypass, a read accepted at edge N sees it at edge N.
  - A read accepted at edge N+1 or later sees it through mem.
- Read latency: 1 cycle. Addresses are sampled at edge N; rd_data_a/b/rd_valid update after edge N and stay stable until the next accepted read, the next non-stall edge, or reset.
- Throughput: one read pair and one write per cycle, with no bubbles.
- No combinational path from any input to any output. All outputs are flop-driven.
- Cycle after reset deassert: rd_valid=0, rd_data_a=rd_data_b=0, all words 0.

## Test plan
- Reset, then basic write/read:
  - Stimulus: rst 2 cycles; write 0xDEADBEEF to addr 5; next cycle read A=5, B=0.
  - Required: rd_data_a=0xDEADBEEF, rd_data_b=0, rd_valid=1 one cycle after the read edge.
- Bypass:
  - Stimulus: addr 7 holds 0x11111111. At one edge, write 0x22222222 to addr 7 and read A=7, B=7.
  - Required: rd_data_a=rd_data_b=0x22222222 after that edge.
- Register 0:
  - Stimulus: write 0xFFFFFFFF to addr 0 and read A=0 at the same edge; then read A=0 again.
  - Required: rd_data_a=0 both times.
- Stall hold:
  - Stimulus: read A=3 (0x00000033), rd_valid=1. Assert stall 3 cycles while writing 0x44 to addr 3 and changing rd_addr_a=9.
  - Required: rd_data_a stays 0x00000033 and rd_valid stays 1 for all 3 cycles.
  - Required: after stall drops, with rd_en=1 and rd_addr_a=3, rd_data_a=0x44.
- Reset mid-operation:
  - Stimulus: fill addrs 1–31 with their index; assert rst for one edge during an active read; then read A=31, B=1.
  - Required: rd_data_a/b=0 and rd_valid=0 the cycle after reset; the subsequent read returns 0 and 0.
- Back-to-back sweep:
  - Stimulus: write addr i with i×0x01010101 for i=1..31 on consecutive cycles, while reading A=i−1, B=i on each cycle.
  - Required: every cycle, rd_data_b equals the value written at that same edge (bypass) and rd_data_a equals the prior write; rd_valid=1 throughout.
